// File: rtl/branch_pkg.sv
// Shared opcodes, funct3 codes, counter states and BTB status type for the branch unit.
package branch_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    BR_EQ   = 3'b000,
    BR_NE   = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_LT   = 3'b100,
    BR_GE   = 3'b101,
    BR_LTU  = 3'b110,
    BR_GEU  = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // Reset-protected part of an entry; tag and target widths depend on XLEN/depth.
  typedef struct packed {
    logic valid;
    ctr_e ctr;
  } btb_entry_t;

  function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
    if (taken) return (c == ST) ? ST : ctr_e'(c + 2'd1);
    return (c == SNT) ? SNT : ctr_e'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// RV32 conditional-branch comparator; purely combinational, no flow control.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  br_type_e        br_type,
  output logic            cond
);

  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_EQ:   cond = (rs1 == rs2);
      BR_NE:   cond = (rs1 != rs2);
      BR_LT:   cond = ($signed(rs1) < $signed(rs2));
      BR_GE:   cond = ($signed(rs1) >= $signed(rs2));
      BR_LTU:  cond = (rs1 < rs2);
      BR_GEU:  cond = (rs1 >= rs2);
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_predict_resolve.sv
// BTB with 2-bit counters read at fetch plus execute-stage branch resolution and training.
// Lookup and resolution are zero-latency; table/perf updates land on the next edge; no backpressure.
module branch_predict_resolve
  import branch_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int BTB_DEPTH = 64,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_pred_taken,
  output logic [XLEN-1:0]   if_pred_target,
  input  logic              ex_valid,
  input  logic [XLEN-1:0]   ex_pc,
  input  logic [XLEN-1:0]   ex_rs1,
  input  logic [XLEN-1:0]   ex_rs2,
  input  logic [XLEN-1:0]   ex_imm,
  input  logic [6:0]        ex_opcode,
  input  logic [2:0]        ex_br_type,
  input  logic              ex_pred_taken,
  input  logic [XLEN-1:0]   ex_pred_target,
  input  logic              btb_clear,
  output logic              ex_br_taken,
  output logic              ex_redirect,
  output logic [XLEN-1:0]   ex_redirect_pc,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = XLEN - IDX_W - 2;

  btb_entry_t       stat_q [BTB_DEPTH];
  logic [TAG_W-1:0] tag_q  [BTB_DEPTH];
  logic [XLEN-1:0]  tgt_q  [BTB_DEPTH];

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             unused_pc_lsb;

  assign if_idx        = if_pc[IDX_W+1:2];
  assign if_tag        = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx        = ex_pc[IDX_W+1:2];
  assign ex_tag        = ex_pc[XLEN-1:IDX_W+2];
  assign unused_pc_lsb = &{1'b0, if_pc[1:0]};

  assign if_hit         = stat_q[if_idx].valid && (tag_q[if_idx] == if_tag);
  assign if_pred_taken  = if_hit && stat_q[if_idx].ctr[1];
  assign if_pred_target = if_pred_taken ? tgt_q[if_idx] : '0;

  logic            is_br, is_jal, is_jalr, is_ctrl, cond, trained, do_write, do_alias;
  logic [XLEN-1:0] jalr_sum, target;
  ctr_e            new_ctr;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .rs1     (ex_rs1),
    .rs2     (ex_rs2),
    .br_type (br_type_e'(ex_br_type)),
    .cond    (cond)
  );

  always_comb begin
    is_br    = (ex_opcode == OP_BRANCH);
    is_jal   = (ex_opcode == OP_JAL);
    is_jalr  = (ex_opcode == OP_JALR);
    is_ctrl  = is_br || is_jal || is_jalr;
    jalr_sum = ex_rs1 + ex_imm;
    target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : ex_pc + ex_imm;
  end

  assign ex_br_taken    = ex_valid && (is_jal || is_jalr || (is_br && cond));
  assign ex_redirect    = ex_valid && ((ex_br_taken != ex_pred_taken) ||
                                       (ex_br_taken && (target != ex_pred_target)));
  assign ex_redirect_pc = ex_br_taken ? target : ex_pc + XLEN'(4);

  // funct3 010/011 are not real branches, so they never touch the table.
  assign trained  = ex_valid && (is_jal || is_jalr || (is_br && (ex_br_type[2:1] != 2'b01)));
  assign ex_hit   = stat_q[ex_idx].valid && (tag_q[ex_idx] == ex_tag);
  assign do_write = trained && (ex_hit || ex_br_taken);
  assign do_alias = ex_valid && !is_ctrl && ex_pred_taken && ex_hit;

  always_comb begin
    new_ctr = ST;
    if (is_br) new_ctr = ex_hit ? ctr_step(stat_q[ex_idx].ctr, ex_br_taken) : WT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BTB_DEPTH; i++) stat_q[i] <= '{valid: 1'b0, ctr: WNT};
    end else if (btb_clear) begin
      for (int i = 0; i < BTB_DEPTH; i++) stat_q[i] <= '{valid: 1'b0, ctr: WNT};
    end else if (do_write) begin
      stat_q[ex_idx] <= '{valid: 1'b1, ctr: new_ctr};
    end else if (do_alias) begin
      stat_q[ex_idx].valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write && ex_br_taken && !btb_clear) begin
      tag_q[ex_idx] <= ex_tag;
      tgt_q[ex_idx] <= target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_branches    <= '0;
      perf_mispredicts <= '0;
    end else begin
      if (trained && (perf_branches != '1))       perf_branches    <= perf_branches + PERF_W'(1);
      if (ex_redirect && (perf_mispredicts != '1)) perf_mispredicts <= perf_mispredicts + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Self-checking bench: directed table, corner-case sequences and random traffic against a BTB model.
module tb_branch_predict_resolve;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm, ex_pred_target;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_br_type;
  logic        ex_pred_taken, btb_clear;
  logic        ex_br_taken, ex_redirect;
  logic [31:0] ex_redirect_pc, perf_branches, perf_mispredicts;

  localparam logic [6:0] OP_ADD = 7'b0110011;

  branch_predict_resolve #(.XLEN(32), .BTB_DEPTH(64), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
    .if_pred_target(if_pred_target), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_opcode(ex_opcode), .ex_br_type(ex_br_type),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target), .btb_clear(btb_clear),
    .ex_br_taken(ex_br_taken), .ex_redirect(ex_redirect), .ex_redirect_pc(ex_redirect_pc),
    .perf_branches(perf_branches), .perf_mispredicts(perf_mispredicts)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 64 entries, index = pc[7:2], tag = pc >> 8
  bit          m_valid [64];
  int unsigned m_ctr   [64];
  logic [31:0] m_tag   [64];
  logic [31:0] m_tgt   [64];
  int unsigned m_br, m_mis;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] pc, rs1, rs2, imm;
    logic        pt;
    logic [31:0] ptg;
    logic        e_taken, e_redir;
    logic [31:0] e_rpc;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_br  = 0;
    m_mis = 0;
  endtask

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  task automatic m_predict(input logic [31:0] pc, output logic pt, output logic [31:0] ptg);
    int i = m_idx(pc);
    pt  = m_valid[i] && (m_tag[i] == (pc >> 8)) && (m_ctr[i] >= 2);
    ptg = pt ? m_tgt[i] : 32'h0;
  endtask

  task automatic m_resolve(output logic t, output logic [31:0] tg, output logic r,
                           output logic [31:0] rpc);
    t  = 1'b0;
    tg = 32'h0;
    if (ex_opcode == OP_BRANCH) begin
      tg = ex_pc + ex_imm;
      case (ex_br_type)
        3'd0: t = (ex_rs1 == ex_rs2);
        3'd1: t = (ex_rs1 != ex_rs2);
        3'd4: t = ($signed(ex_rs1) < $signed(ex_rs2));
        3'd5: t = ($signed(ex_rs1) >= $signed(ex_rs2));
        3'd6: t = (ex_rs1 < ex_rs2);
        3'd7: t = (ex_rs1 >= ex_rs2);
        default: t = 1'b0;
      endcase
    end else if (ex_opcode == OP_JAL) begin
      t  = 1'b1;
      tg = ex_pc + ex_imm;
    end else if (ex_opcode == OP_JALR) begin
      t  = 1'b1;
      tg = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
    end
    if (!ex_valid) t = 1'b0;
    r   = ex_valid && ((t != ex_pred_taken) || (t && (tg != ex_pred_target)));
    rpc = t ? tg : ex_pc + 32'd4;
  endtask

  task automatic m_edge();
    logic t, r;
    logic [31:0] tg, rpc;
    int i;
    bit hit, br, jmp, trn;
    m_resolve(t, tg, r, rpc);
    i   = m_idx(ex_pc);
    hit = m_valid[i] && (m_tag[i] == (ex_pc >> 8));
    br  = (ex_opcode == OP_BRANCH);
    jmp = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
    trn = ex_valid && (jmp || (br && ex_br_type != 3'd2 && ex_br_type != 3'd3));
    if (trn && m_br != 32'hFFFF_FFFF) m_br++;
    if (r && m_mis != 32'hFFFF_FFFF) m_mis++;
    if (btb_clear) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 1'b0;
        m_ctr[k]   = 1;
      end
    end else if (trn) begin
      if (hit) begin
        if (jmp) begin
          m_ctr[i] = 3;
          m_tgt[i] = tg;
        end else if (t) begin
          m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
          m_tgt[i] = tg;
        end else begin
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
        end
      end else if (t) begin
        m_valid[i] = 1'b1;
        m_tag[i]   = ex_pc >> 8;
        m_tgt[i]   = tg;
        m_ctr[i]   = jmp ? 3 : 2;
      end
    end else if (ex_valid && !br && !jmp && ex_pred_taken && hit) begin
      m_valid[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    logic pt, t, r;
    logic [31:0] ptg, tg, rpc;
    m_predict(if_pc, pt, ptg);
    m_resolve(t, tg, r, rpc);
    chk("if_pred_taken", 32'(if_pred_taken), 32'(pt));
    chk("if_pred_target", if_pred_target, ptg);
    chk("ex_br_taken", 32'(ex_br_taken), 32'(t));
    chk("ex_redirect", 32'(ex_redirect), 32'(r));
    chk("ex_redirect_pc", ex_redirect_pc, rpc);
    chk("perf_branches", perf_branches, m_br);
    chk("perf_mispredicts", perf_mispredicts, m_mis);
  endtask

  // Inputs are driven at negedge; check mid-cycle, then advance the model on the edge.
  task automatic step();
    #1 check_all();
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic pt, input logic [31:0] ptg);
    ex_valid = v;  ex_opcode = op;  ex_br_type = f3;  ex_pc = pc;
    ex_rs1 = rs1;  ex_rs2 = rs2;    ex_imm = imm;
    ex_pred_taken = pt;  ex_pred_target = ptg;
  endtask

  task automatic idle();
    drive(1'b0, OP_ADD, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{1'b1, OP_BRANCH, 3'd1, 32'h400, 32'd5, 32'd5, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h404};
    vecs[1]  = '{1'b1, OP_BRANCH, 3'd4, 32'h408, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h448};
    vecs[2]  = '{1'b1, OP_BRANCH, 3'd6, 32'h40C, 32'hFFFF_FFFF, 32'd1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h410};
    vecs[3]  = '{1'b1, OP_BRANCH, 3'd5, 32'h410, 32'hFFFF_FFFF, 32'd1, 32'h8, 1'b1, 32'h418, 1'b0, 1'b1, 32'h414};
    vecs[4]  = '{1'b1, OP_BRANCH, 3'd7, 32'h414, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF0, 1'b1, 32'h404, 1'b1, 1'b0, 32'h404};
    vecs[5]  = '{1'b1, OP_BRANCH, 3'd2, 32'h418, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b0, 1'b0, 32'h41C};
    vecs[6]  = '{1'b1, OP_JAL, 3'd0, 32'h41C, 32'd0, 32'd0, 32'h100, 1'b1, 32'h51C, 1'b1, 1'b0, 32'h51C};
    vecs[7]  = '{1'b1, OP_JALR, 3'd0, 32'h420, 32'h201, 32'd0, 32'h4, 1'b1, 32'h204, 1'b1, 1'b0, 32'h204};
    vecs[8]  = '{1'b1, OP_JALR, 3'd0, 32'h424, 32'h201, 32'd0, 32'h4, 1'b1, 32'h200, 1'b1, 1'b1, 32'h204};
    vecs[9]  = '{1'b1, OP_JAL, 3'd0, 32'hFFFF_FFFC, 32'd0, 32'd0, 32'h8, 1'b0, 32'h0, 1'b1, 1'b1, 32'h4};
    vecs[10] = '{1'b1, OP_ADD, 3'd0, 32'h430, 32'd1, 32'd2, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h434};
    vecs[11] = '{1'b0, OP_BRANCH, 3'd0, 32'h440, 32'd7, 32'd7, 32'h20, 1'b0, 32'h0, 1'b0, 1'b0, 32'h444};

    btb_clear = 1'b0;
    if_pc     = 32'h100;
    idle();
    m_reset();
    #12;
    chk("reset_pred_taken", 32'(if_pred_taken), 32'd0);
    chk("reset_pred_target", if_pred_target, 32'h0);
    chk("reset_redirect", 32'(ex_redirect), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    #1;
    chk("cold_pred_taken", 32'(if_pred_taken), 32'd0);
    chk("cold_perf_br", perf_branches, 32'd0);
    chk("cold_perf_mis", perf_mispredicts, 32'd0);

    // BEQ taken on a cold table; same-cycle fetch still sees the old entry
    drive(1'b1, OP_BRANCH, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    #1;
    chk("beq_taken", 32'(ex_br_taken), 32'd1);
    chk("beq_redirect", 32'(ex_redirect), 32'd1);
    chk("beq_redirect_pc", ex_redirect_pc, 32'h120);
    chk("no_bypass", 32'(if_pred_taken), 32'd0);
    step();
    idle();
    #1;
    chk("alloc_pred_taken", 32'(if_pred_taken), 32'd1);
    chk("alloc_pred_target", if_pred_target, 32'h120);
    chk("alloc_perf_mis", perf_mispredicts, 32'd1);
    chk("alloc_perf_br", perf_branches, 32'd1);
    step();

    // Counter walks 10 -> 01 -> 00 -> 00, then taken gives 01 (still not predicted)
    drive(1'b1, OP_BRANCH, 3'd0, 32'h100, 32'd5, 32'd6, 32'h20, 1'b1, 32'h120);
    #1;
    chk("nt_redirect", 32'(ex_redirect), 32'd1);
    chk("nt_redirect_pc", ex_redirect_pc, 32'h104);
    step();
    idle();
    #1 chk("wnt_pred_taken", 32'(if_pred_taken), 32'd0);
    step();
    drive(1'b1, OP_BRANCH, 3'd0, 32'h100, 32'd5, 32'd6, 32'h20, 1'b0, 32'h0);
    step();
    step();
    drive(1'b1, OP_BRANCH, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    step();
    idle();
    #1 chk("snt_saturates", 32'(if_pred_taken), 32'd0);
    step();
    drive(1'b1, OP_BRANCH, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1'b0, 32'h0);
    step();
    idle();
    #1 chk("wt_pred_taken", 32'(if_pred_taken), 32'd1);
    step();

    // Non-control instruction aliasing a predicted-taken entry
    drive(1'b1, OP_ADD, 3'd0, 32'h100, 32'd0, 32'd0, 32'h0, 1'b1, 32'h120);
    #1;
    chk("alias_redirect", 32'(ex_redirect), 32'd1);
    chk("alias_redirect_pc", ex_redirect_pc, 32'h104);
    step();
    idle();
    #1 chk("alias_invalidated", 32'(if_pred_taken), 32'd0);
    step();

    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].v, vecs[v].op, vecs[v].f3, vecs[v].pc, vecs[v].rs1, vecs[v].rs2,
            vecs[v].imm, vecs[v].pt, vecs[v].ptg);
      #1;
      chk($sformatf("vec%0d_taken", v), 32'(ex_br_taken), 32'(vecs[v].e_taken));
      chk($sformatf("vec%0d_redirect", v), 32'(ex_redirect), 32'(vecs[v].e_redir));
      chk($sformatf("vec%0d_redirect_pc", v), ex_redirect_pc, vecs[v].e_rpc);
      step();
    end

    idle();
    if_pc = 32'h41C;
    #1 chk("jal_pred_before_clear", 32'(if_pred_taken), 32'd1);
    drive(1'b1, OP_BRANCH, 3'd0, 32'h200, 32'd1, 32'd1, 32'h40, 1'b0, 32'h0);
    btb_clear = 1'b1;
    step();
    btb_clear = 1'b0;
    idle();
    if_pc = 32'h200;
    #1 chk("clear_beats_train", 32'(if_pred_taken), 32'd0);
    step();
    if_pc = 32'h41C;
    #1 chk("clear_all_entries", 32'(if_pred_taken), 32'd0);
    step();

    for (int c = 0; c < 400; c++) begin
      logic [31:0] pc, imm, ptg;
      logic        pt;
      logic [6:0]  op;
      pc  = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      imm = 32'($urandom_range(0, 63) * 4) - 32'd128;
      case ($urandom_range(0, 3))
        0: op = OP_JAL;
        1: op = OP_JALR;
        2: op = OP_ADD;
        default: op = OP_BRANCH;
      endcase
      if ($urandom_range(0, 1) == 1) m_predict(pc, pt, ptg);
      else begin
        pt  = 1'($urandom_range(0, 1));
        ptg = pc + imm;
      end
      drive(($urandom_range(0, 4) != 0), op, 3'($urandom_range(0, 7)), pc,
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom,
            ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 3)) : $urandom,
            imm, pt, ptg);
      btb_clear = ($urandom_range(0, 49) == 0);
      if_pc = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      step();
    end
    btb_clear = 1'b0;

    // Asynchronous reset in the middle of operation
    drive(1'b1, OP_JAL, 3'd0, 32'h600, 32'd0, 32'd0, 32'h40, 1'b0, 32'h0);
    step();
    idle();
    if_pc = 32'h600;
    #1;
    chk("pre_reset_pred", 32'(if_pred_taken), 32'd1);
    chk("pre_reset_target", if_pred_target, 32'h640);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_pred", 32'(if_pred_taken), 32'd0);
    chk("midreset_perf_br", perf_branches, 32'd0);
    chk("midreset_perf_mis", perf_mispredicts, 32'd0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
